fifo_wrif_sk: RTL and testbench
===============================

FIFO_WRIF_SK -- requirements
Module: fifo_wrif_sk

Interface
REQ-001 SHALL have parameter DWID, default 18: data width.
REQ-002 SHALL have parameter USE_AFULL, default 0: when 1, drain is additionally gated by nafull.
REQ-003 SHALL have parameter DBG_WID, default 32: debug bus width.
REQ-004 SHALL have port clk, input, 1: single clock for all logic.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port flush, input, 1: synchronous discard of the buffered entries.
REQ-007 SHALL have port in_vld, input, 1: upstream data valid.
REQ-008 SHALL have port in_data, input, DWID: upstream data.
REQ-009 SHALL have port in_rdy, output, 1: block can accept a word this cycle.
REQ-010 SHALL have port wen, output, 1: write enable to the downstream FIFO.
REQ-011 SHALL have port wdata, output, DWID: write data to the downstream FIFO.
REQ-012 SHALL have port nfull, input, 1: downstream FIFO not full.
REQ-013 SHALL have port nafull, input, 1: downstream FIFO not almost-full.
REQ-014 SHALL have port push_cnt, output, 32: count of words written downstream.
REQ-015 SHALL have port stall_cnt, output, 32: count of cycles blocked by the downstream FIFO.
REQ-016 SHALL have port dbg_sig, output, DBG_WID: debug bus.

Function
REQ-017 SHALL hold a 2-entry skid buffer (entry0/entry1, 1-bit wr_ptr, 1-bit rd_ptr, 2-bit occ, range 0..2).
REQ-018 SHALL drive in_rdy = (occ != 2), decoded directly from registered occ, with no combinational path from nfull or nafull.
REQ-019 SHALL accept a word when acc = in_vld & in_rdy: write in_data to entry[wr_ptr], then toggle wr_ptr.
REQ-020 SHALL define drain_ok = nfull when USE_AFULL=0, and nfull & nafull when USE_AFULL=1.
REQ-021 SHALL drive wen = (occ != 0) & drain_ok & ~flush, and wdata = entry[rd_ptr]; wdata is don't-care when wen=0.
REQ-022 SHALL toggle rd_ptr on each wen.
REQ-023 SHALL update occ as: acc & ~wen -> +1; wen & ~acc -> -1; both or neither -> unchanged; occ never exceeds 2 and never goes below 0.
REQ-024 SHALL give a minimum latency of 1 cycle: a word accepted in cycle N appears on wen/wdata no earlier than cycle N+1 (no bypass).
REQ-025 SHALL sustain one word per cycle while drain_ok stays 1.
REQ-026 SHALL preserve word order exactly; no word is dropped or duplicated.
REQ-027 SHALL, on flush=1 in a cycle, set occ=0 and wr_ptr=rd_ptr=0 at that edge, force wen=0, and ignore acc in that cycle; in_rdy still reflects the pre-flush occ.
REQ-028 SHALL increment push_cnt on each wen, wrapping 0xFFFFFFFF -> 0.
REQ-029 SHALL increment stall_cnt on cycles with (occ != 0) & ~drain_ok & ~flush, wrapping 0xFFFFFFFF -> 0.
REQ-030 SHALL never assert wen while nfull=0, including when nfull falls with occ=2.
REQ-031 SHALL drive dbg_sig = {zero pad, occ[1:0], in_rdy, wen, drain_ok}, with the low 5 bits in the order listed.

Reset
REQ-032 SHALL, while rst=1 and independent of clk, force occ=0, wr_ptr=0, rd_ptr=0, push_cnt=0, stall_cnt=0, and entry0/entry1 to 0.
REQ-033 SHALL therefore present outputs in_rdy=1, wen=0, wdata=0, push_cnt=0, stall_cnt=0 during reset.
REQ-034 SHALL, on reset asserted mid-transfer, discard all buffered words; after release, in_rdy=1 and the first accepted word is the first one written downstream.

Verification
REQ-035 SHALL pass this check: nfull=1, nafull=1; stream 0x00001..0x00010 with in_vld held 1 -> 16 wen pulses on consecutive cycles, data 0x00001..0x00010 in order; push_cnt=16; stall_cnt=0; occ never exceeds 1.
REQ-036 SHALL pass this check: nfull=0; offer 3 words A,B,C -> A and B accepted, in_rdy=0 with occ=2, wen=0, and stall_cnt increments each cycle; raise nfull -> wen carries A then B, and C is accepted in the first cycle that in_rdy=1.
REQ-037 SHALL pass this check: USE_AFULL=1, nfull=1, nafull=0 with occ=1 for 5 cycles -> wen=0 and stall_cnt=5; with USE_AFULL=0 under the same stimulus -> wen=1 in the first cycle.
REQ-038 SHALL pass this check: occ=2, pulse flush for 1 cycle with in_vld=1 -> wen=0 in that cycle, occ=0 next cycle, the flushed and offered words never appear downstream, and push_cnt is unchanged.
REQ-039 SHALL pass this check: assert rst asynchronously between clock edges with occ=2 -> wen=0 and in_rdy=1 immediately; after release, write 0x3FFFF -> a single wen with wdata=0x3FFFF and push_cnt=1.
REQ-040 SHALL pass this check: preload push_cnt near 0xFFFFFFFF (force), then two writes -> push_cnt wraps to 0x00000000, then 0x00000001.

Source files
------------

// File: rtl/fifo_wrif_sk_if.sv
// Handshake bundle between an upstream valid/ready source, the skid buffer and a downstream FIFO write port.
// Slave is the skid buffer's view; master is the view of whatever drives in_vld, in_data, nfull and nafull.
interface fifo_wrif_sk_if #(
    parameter int DWID = 18
);
    logic            in_vld;
    logic [DWID-1:0] in_data;
    logic            in_rdy;
    logic            wen;
    logic [DWID-1:0] wdata;
    logic            nfull;
    logic            nafull;

    modport slave (
        input  in_vld,
        input  in_data,
        input  nfull,
        input  nafull,
        output in_rdy,
        output wen,
        output wdata
    );

    modport master (
        output in_vld,
        output in_data,
        output nfull,
        output nafull,
        input  in_rdy,
        input  wen,
        input  wdata
    );
endinterface

// File: rtl/fifo_wrif_sk.sv
// Two-entry skid buffer feeding a FIFO write port; words take at least 1 cycle, throughput is 1 word/cycle.
// in_rdy comes only from registered occupancy, so the downstream full flags never reach the upstream ready.
module fifo_wrif_sk #(
    parameter int DWID      = 18,
    parameter int USE_AFULL = 0,
    parameter int DBG_WID   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    fifo_wrif_sk_if.slave      bus,
    output logic [31:0]        push_cnt,
    output logic [31:0]        stall_cnt,
    output logic [DBG_WID-1:0] dbg_sig
);

    logic [DWID-1:0] entry_q [2];
    logic [DWID-1:0] entry_d [2];
    logic            wr_ptr_q, wr_ptr_d;
    logic            rd_ptr_q, rd_ptr_d;
    logic [1:0]      occ_q, occ_d;
    logic [31:0]     push_cnt_q, push_cnt_d;
    logic [31:0]     stall_cnt_q, stall_cnt_d;

    logic            drain_ok;
    logic            in_rdy;
    logic            acc;
    logic            wen;
    logic            stall;
    logic [4:0]      dbg_lo;

    assign drain_ok = (USE_AFULL != 0) ? (bus.nfull & bus.nafull) : bus.nfull;
    assign in_rdy   = (occ_q != 2'd2);
    // A flush cycle swallows the offered word as well as the buffered ones.
    assign acc      = bus.in_vld & in_rdy & ~flush;
    assign wen      = (occ_q != 2'd0) & drain_ok & ~flush;
    assign stall    = (occ_q != 2'd0) & ~drain_ok & ~flush;

    assign bus.in_rdy = in_rdy;
    assign bus.wen    = wen;
    assign bus.wdata  = entry_q[rd_ptr_q];

    assign push_cnt  = push_cnt_q;
    assign stall_cnt = stall_cnt_q;
    assign dbg_lo    = {occ_q, in_rdy, wen, drain_ok};
    assign dbg_sig   = DBG_WID'(dbg_lo);

    always_comb begin
        entry_d     = entry_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        occ_d       = occ_q;
        push_cnt_d  = push_cnt_q + {31'd0, wen};
        stall_cnt_d = stall_cnt_q + {31'd0, stall};
        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            occ_d    = 2'd0;
        end else begin
            if (acc) begin
                entry_d[wr_ptr_q] = bus.in_data;
                wr_ptr_d          = ~wr_ptr_q;
            end
            if (wen) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case ({acc, wen})
                2'b10:   occ_d = occ_q + 2'd1;
                2'b01:   occ_d = occ_q - 2'd1;
                default: occ_d = occ_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry_q[0]  <= '0;
            entry_q[1]  <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            occ_q       <= 2'd0;
            push_cnt_q  <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            entry_q[0]  <= entry_d[0];
            entry_q[1]  <= entry_d[1];
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            push_cnt_q  <= push_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_wrif_sk.sv
// Bench for fifo_wrif_sk: one instance per drain-gating mode, both driven identically.
// Each instance is compared every cycle against a queue model of the buffered words.
module tb_fifo_wrif_sk;

    localparam int DW = 18;

    logic clk;
    logic rst;
    logic flush;
    logic in_vld;
    logic [DW-1:0] in_data;
    logic nfull;
    logic nafull;

    logic          rdy_o   [2];
    logic          wen_o   [2];
    logic [DW-1:0] wdata_o [2];
    logic [31:0]   push_o  [2];
    logic [31:0]   stall_o [2];
    logic [31:0]   dbg_o   [2];

    fifo_wrif_sk_if #(.DWID(DW)) if0 ();
    fifo_wrif_sk_if #(.DWID(DW)) if1 ();

    assign if0.in_vld  = in_vld;
    assign if0.in_data = in_data;
    assign if0.nfull   = nfull;
    assign if0.nafull  = nafull;
    assign if1.in_vld  = in_vld;
    assign if1.in_data = in_data;
    assign if1.nfull   = nfull;
    assign if1.nafull  = nafull;

    assign rdy_o[0]   = if0.in_rdy;
    assign wen_o[0]   = if0.wen;
    assign wdata_o[0] = if0.wdata;
    assign rdy_o[1]   = if1.in_rdy;
    assign wen_o[1]   = if1.wen;
    assign wdata_o[1] = if1.wdata;

    fifo_wrif_sk #(.DWID(DW), .USE_AFULL(0), .DBG_WID(32)) dut0 (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .bus       (if0.slave),
        .push_cnt  (push_o[0]),
        .stall_cnt (stall_o[0]),
        .dbg_sig   (dbg_o[0])
    );

    fifo_wrif_sk #(.DWID(DW), .USE_AFULL(1), .DBG_WID(32)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .bus       (if1.slave),
        .push_cnt  (push_o[1]),
        .stall_cnt (stall_o[1]),
        .dbg_sig   (dbg_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: words held in the buffer, plus the two counters.
    logic [DW-1:0] mq [2][$];
    logic [31:0]   pc [2];
    logic [31:0]   sc [2];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mq[i].delete();
            pc[i] = 32'd0;
            sc[i] = 32'd0;
        end
    endtask

    task automatic reset_check();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_in_rdy%0d", i), 64'(rdy_o[i]), 64'd1);
            chk($sformatf("rst_wen%0d", i), 64'(wen_o[i]), 64'd0);
            chk($sformatf("rst_wdata%0d", i), 64'(wdata_o[i]), 64'd0);
            chk($sformatf("rst_push%0d", i), 64'(push_o[i]), 64'd0);
            chk($sformatf("rst_stall%0d", i), 64'(stall_o[i]), 64'd0);
        end
    endtask

    // Applies one cycle of inputs at a falling edge, checks both instances, then advances the model.
    task automatic cycle(input logic v, input logic [DW-1:0] d, input logic nf, input logic naf,
                         input logic fl, output logic acc0);
        in_vld  = v;
        in_data = d;
        nfull   = nf;
        nafull  = naf;
        flush   = fl;
        acc0    = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            logic       dok;
            logic       erdy;
            logic       ewen;
            logic [1:0] occ;
            occ  = 2'(mq[i].size());
            dok  = nf & ((i == 0) ? 1'b1 : naf);
            erdy = (occ != 2'd2);
            ewen = (occ != 2'd0) & dok & ~fl;
            chk($sformatf("in_rdy%0d", i), 64'(rdy_o[i]), 64'(erdy));
            chk($sformatf("wen%0d", i), 64'(wen_o[i]), 64'(ewen));
            if (ewen) chk($sformatf("wdata%0d", i), 64'(wdata_o[i]), 64'(mq[i][0]));
            chk($sformatf("push_cnt%0d", i), 64'(push_o[i]), 64'(pc[i]));
            chk($sformatf("stall_cnt%0d", i), 64'(stall_o[i]), 64'(sc[i]));
            chk($sformatf("dbg%0d", i), 64'(dbg_o[i]), 64'({occ, erdy, ewen, dok}));
            if (i == 0) acc0 = v & erdy & ~fl;
            if (fl) begin
                mq[i].delete();
            end else begin
                if (ewen) void'(mq[i].pop_front());
                if (v & erdy) mq[i].push_back(d);
            end
            if (ewen) pc[i] = pc[i] + 32'd1;
            if ((occ != 2'd0) && !dok && !fl) sc[i] = sc[i] + 32'd1;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        logic a;
        for (int k = 0; k < n; k++) cycle(1'b0, '0, 1'b1, 1'b1, 1'b0, a);
    endtask

    initial begin
        logic a;
        logic got;
        rst     = 1'b1;
        flush   = 1'b0;
        in_vld  = 1'b0;
        in_data = '0;
        nfull   = 1'b1;
        nafull  = 1'b1;
        model_reset();
        #1;
        reset_check();
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back stream with an always-ready sink.
        for (int k = 1; k <= 16; k++) cycle(1'b1, DW'(k), 1'b1, 1'b1, 1'b0, a);
        idle(3);

        // Sink full: two words fill the buffer, the third waits for space.
        cycle(1'b1, 18'h0000A, 1'b0, 1'b1, 1'b0, a);
        cycle(1'b1, 18'h0000B, 1'b0, 1'b1, 1'b0, a);
        repeat (3) cycle(1'b1, 18'h0000C, 1'b0, 1'b1, 1'b0, a);
        got = 1'b0;
        for (int k = 0; k < 6 && !got; k++) begin
            cycle(1'b1, 18'h0000C, 1'b1, 1'b1, 1'b0, a);
            got = a;
        end
        idle(3);

        // Almost-full held low with one word buffered.
        cycle(1'b1, 18'h00111, 1'b1, 1'b0, 1'b0, a);
        repeat (5) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, a);
        idle(3);

        // Flush a full buffer while a new word is offered.
        cycle(1'b1, 18'h00021, 1'b0, 1'b1, 1'b0, a);
        cycle(1'b1, 18'h00022, 1'b0, 1'b1, 1'b0, a);
        cycle(1'b1, 18'h00023, 1'b1, 1'b1, 1'b1, a);
        idle(3);

        // Asynchronous reset between edges with the buffer full.
        cycle(1'b1, 18'h00031, 1'b0, 1'b1, 1'b0, a);
        cycle(1'b1, 18'h00032, 1'b0, 1'b1, 1'b0, a);
        in_vld = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        reset_check();
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        cycle(1'b1, 18'h3FFFF, 1'b1, 1'b1, 1'b0, a);
        idle(3);

        // Push counter wrap from a preloaded value.
        force dut0.push_cnt_q = 32'hFFFF_FFFF;
        pc[0] = 32'hFFFF_FFFF;
        idle(1);
        release dut0.push_cnt_q;
        cycle(1'b1, 18'h00041, 1'b1, 1'b1, 1'b0, a);
        cycle(1'b1, 18'h00042, 1'b1, 1'b1, 1'b0, a);
        idle(3);

        // Randomized traffic, sink flags and occasional flushes.
        for (int k = 0; k < 1500; k++) begin
            cycle(1'($urandom_range(0, 3) != 0), DW'($urandom),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) < 7),
                  1'($urandom_range(0, 31) == 0), a);
        end
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
